// File: rtl/ifq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifq_pkg
//  Description : Shared types and constants for the instruction fetch queue.
//                IFQ_NOP  - instruction presented to decode when the queue is
//                           empty (addi x0, x0, 0).
//                IFQ_XLEN - default instruction / PC width.
//                ifq_entry_t - one queued {instruction, PC} pair.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifq_pkg;

    localparam int IFQ_XLEN = 32;

    localparam logic [31:0] IFQ_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [IFQ_XLEN-1:0] inst;
        logic [IFQ_XLEN-1:0] pc;
    } ifq_entry_t;

endpackage : ifq_pkg
`default_nettype wire

// File: rtl/ifq_mem.sv
`default_nettype none
// ============================================================================
//  Module      : ifq_mem
//  Description : DEPTH x ifq_entry_t register array backing the fetch queue.
//                One synchronous write port, one asynchronous read port.
//                Contents are deliberately not reset; validity is tracked by
//                the occupancy counter in the parent.
//  Ports       : clk   - clock
//                we    - write enable
//                waddr - write index
//                wdata - entry to store
//                raddr - read index
//                rdata - entry at raddr (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module ifq_mem
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  ifq_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output ifq_entry_t    rdata
);

    ifq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : ifq_mem
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_queue
//  Description : Decoupling queue between instruction fetch and decode.
//                Holds up to DEPTH {instruction, PC} pairs in a circular
//                buffer, presents the oldest pair to decode via valid/ready,
//                back-pressures fetch when full and empties in one cycle on
//                flush (branch redirect).
//  Build option: IFQ_BYPASS_EN - when defined, an empty queue forwards the
//                fetch pair straight to decode in the same cycle; if decode
//                accepts it, the pair is never written into the buffer.
//  Ports       : clk        - clock, all state changes on rising edge
//                rst        - synchronous active-high reset
//                flush      - discard all entries (wins over push and pop)
//                if_valid   - fetch offers a pair
//                if_inst    - fetched instruction
//                if_pc      - PC of if_inst
//                if_ready   - queue can accept a push this cycle
//                pc_stall_o - inverse of if_ready, holds the fetch PC
//                id_valid   - id_inst / id_pc are valid
//                id_inst    - oldest instruction (NOP when invalid)
//                id_pc      - oldest PC (0 when invalid)
//                id_ready   - decode consumes the head this cycle
//                count_o    - current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = IFQ_XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       if_valid,
    input  logic [XLEN-1:0]            if_inst,
    input  logic [XLEN-1:0]            if_pc,
    output logic                       if_ready,
    output logic                       pc_stall_o,
    output logic                       id_valid,
    output logic [XLEN-1:0]            id_inst,
    output logic [XLEN-1:0]            id_pc,
    input  logic                       id_ready,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);

    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    // Pointer wrap relies on natural binary overflow, so DEPTH must be a
    // power of two. The entry type is sized by the package width.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("inst_fetch_queue: DEPTH must be a power of two >= 2");
    end

    if (XLEN != IFQ_XLEN) begin : g_xlen_check
        $error("inst_fetch_queue: XLEN must equal ifq_pkg::IFQ_XLEN");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic       w_empty;
    logic       w_if_ready;
    logic       w_bypass_vld;
    logic       w_bypass_take;
    logic       w_push;
    logic       w_pop;
    ifq_entry_t w_wdata;
    ifq_entry_t w_rdata;

    assign w_empty    = (r_count == '0);
    // Full refuses a push even when a pop happens in the same cycle, which
    // keeps if_ready free of any dependency on id_ready.
    assign w_if_ready = (r_count != c_full_cnt);

`ifdef IFQ_BYPASS_EN
    // Empty queue forwards the live fetch pair to decode.
    assign w_bypass_vld = w_empty && !flush && if_valid;
`else
    assign w_bypass_vld = 1'b0;
`endif

    // A forwarded pair that decode accepts is consumed without touching the
    // buffer; otherwise it is written like any other push.
    assign w_bypass_take = w_bypass_vld && id_ready;

    assign w_push = if_valid && w_if_ready && !flush && !w_bypass_take;
    // Pop only ever comes from stored entries; a forwarded pair is not a pop.
    assign w_pop  = !w_empty && id_ready && !flush;

    assign w_wdata.inst = if_inst;
    assign w_wdata.pc   = if_pc;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    ifq_mem #(
        .DEPTH (DEPTH),
        .AW    (c_ptr_w)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (w_wdata),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // id_* are intentionally not masked by flush; decode qualifies them.
    assign if_ready   = w_if_ready;
    assign pc_stall_o = !w_if_ready;
    assign count_o    = r_count;

`ifdef IFQ_BYPASS_EN
    always_comb begin
        id_valid = 1'b0;
        id_inst  = XLEN'(IFQ_NOP);
        id_pc    = '0;
        if (!w_empty) begin
            id_valid = 1'b1;
            id_inst  = w_rdata.inst;
            id_pc    = w_rdata.pc;
        end else if (w_bypass_vld) begin
            id_valid = 1'b1;
            id_inst  = if_inst;
            id_pc    = if_pc;
        end
    end
`else
    always_comb begin
        id_valid = 1'b0;
        id_inst  = XLEN'(IFQ_NOP);
        id_pc    = '0;
        if (!w_empty) begin
            id_valid = 1'b1;
            id_inst  = w_rdata.inst;
            id_pc    = w_rdata.pc;
        end
    end
`endif

endmodule : inst_fetch_queue
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_queue
//  Description : Self-checking bench for inst_fetch_queue. A queue-based
//                reference model predicts every output; directed steps
//                cover reset, fill, drain, wrap, flush and bypass, followed
//                by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

    localparam int          DEPTH = 4;
    localparam int          XLEN  = 32;
    localparam int          CW    = $clog2(DEPTH+1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            if_valid;
    logic [XLEN-1:0] if_inst;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;
    logic            pc_stall_o;
    logic            id_valid;
    logic [XLEN-1:0] id_inst;
    logic [XLEN-1:0] id_pc;
    logic            id_ready;
    logic [CW-1:0]   count_o;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: oldest entry at index 0, each element {inst, pc}.
    logic [63:0] mq [$];

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .pc_stall_o (pc_stall_o),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_ready   (id_ready),
        .count_o    (count_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic model_bypass();
`ifdef IFQ_BYPASS_EN
        return (mq.size() == 0) && if_valid && !flush;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs();
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        if (mq.size() != 0) begin
            ev = 1'b1;
            ei = mq[0][63:32];
            ep = mq[0][31:0];
        end else if (model_bypass()) begin
            ev = 1'b1;
            ei = if_inst;
            ep = if_pc;
        end else begin
            ev = 1'b0;
            ei = NOP;
            ep = '0;
        end
        chk("id_valid",   id_valid,   ev);
        chk("id_inst",    id_inst,    ei);
        chk("id_pc",      id_pc,      ep);
        chk("if_ready",   if_ready,   mq.size() < DEPTH);
        chk("pc_stall_o", pc_stall_o, mq.size() >= DEPTH);
        chk("count_o",    count_o,    mq.size());
    endtask

    // Apply inputs just after the falling edge and check the outputs that
    // result before the next rising edge.
    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy,
                         input logic fl, input logic rs);
        @(negedge clk);
        if_valid = v;
        if_pc    = pc;
        if_inst  = 32'hA500_0000 ^ pc ^ 32'($urandom_range(0, 255) << 24);
        id_ready = rdy;
        flush    = fl;
        rst      = rs;
        #1;
        if (!rs) check_outputs();
    endtask

    // Rising edge plus model update from the inputs sampled there.
    task automatic tick();
        logic byp_take;
        logic push_ok;
        logic pop_ok;
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            byp_take = model_bypass() && id_ready;
            if (!byp_take) begin
                push_ok = if_valid && (mq.size() < DEPTH);
                pop_ok  = (mq.size() > 0) && id_ready;
                if (pop_ok)  void'(mq.pop_front());
                if (push_ok) mq.push_back({if_inst, if_pc});
            end
        end
    endtask

    initial begin
        // Reset, then idle
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_id_valid", id_valid, 1'b0);
        chk("reset_id_inst",  id_inst,  32'h13);
        chk("reset_if_ready", if_ready, 1'b1);
        chk("reset_count",    count_o,  0);
        tick();

        // Fill to DEPTH with decode stalled; the fifth push must be refused
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b1, 32'(4 * k), 1'b0, 1'b0, 1'b0); tick();
        end
        drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        chk("full_count",    count_o,    DEPTH);
        chk("full_if_ready", if_ready,   1'b0);
        chk("full_stall",    pc_stall_o, 1'b1);
        chk("full_head_pc",  id_pc,      32'h0);
        tick();

        // Drain from full in order; 0x10 must not appear
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            chk("drain_pc", id_pc, 32'(4 * k));
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("drained_id_valid", id_valid, 1'b0);
        tick();

        // Sustained push + pop with wrap-around at occupancy 1
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0); tick();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 32'(32'h100 + 4 * k), 1'b1, 1'b0, 1'b0);
            chk("stream_count", count_o, 1);
            chk("stream_pc",    id_pc,   32'(32'h100 + 4 * (k - 1)));
            tick();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("stream_last_pc", id_pc, 32'h128);
        tick();

        // Flush with a concurrent push: the pushed pair is dropped
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'(32'h30 + 4 * k), 1'b0, 1'b0, 1'b0); tick();
        end
        drive(1'b1, 32'h40, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("flush_count",    count_o,  0);
        chk("flush_id_valid", id_valid, 1'b0);
        chk("flush_if_ready", if_ready, 1'b1);
        tick();

        // Empty queue, fetch and decode both ready
        drive(1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
`ifdef IFQ_BYPASS_EN
        chk("bypass_same_cycle_pc", id_pc,    32'h80);
        chk("bypass_same_cycle_v",  id_valid, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("bypass_count", count_o, 0);
        tick();
`else
        chk("nobypass_same_cycle_v", id_valid, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("nobypass_next_pc",    id_pc,    32'h80);
        chk("nobypass_next_count", count_o,  1);
        tick();
`endif

        // Randomized traffic: first biased toward filling, then balanced
        for (int k = 0; k < 300; k++) begin
            drive(($urandom % 4) != 0,
                  $urandom & 32'hFFFF_FFFC,
                  (k < 150) ? (($urandom % 3) == 0) : (($urandom % 3) != 0),
                  ($urandom % 20) == 0,
                  ($urandom % 60) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_inst_fetch_queue
`default_nettype wire
